axi_sram_slave: RTL
===================

# axi_sram_slave

AXI4 slave that terminates one bridge slave port and drives a single-port synchronous SRAM macro. It sits directly downstream of the AXI bridge and consumes the instruction-fetch and data read/write bursts issued by the CPU-side masters. It supports INCR bursts of 1–16 word beats, zero-bubble read bursts under R-channel backpressure, and byte-strobed writes.

## Interface
- ID_WIDTH, 8: slave-side ID width (bridge-extended master ID).
- ADDR_WIDTH, 32: AXI address width.
- DATA_WIDTH, 32: AXI/SRAM data width.
- SRAM_AW, 14: SRAM word-address width (64 KiB region).
- clk  in  1  sole clock.
- rst  in  1  reset; asynchronous, active-high.
- ARID_S / ARADDR_S / ARLEN_S[3:0] / ARSIZE_S[2:0] / ARBURST_S[1:0] / ARVALID_S  in: read address channel.
- ARREADY_S  out  1: read address ready.
- RID_S / RDATA_S / RRESP_S[1:0] / RLAST_S / RVALID_S  out: read data channel.
- RREADY_S  in  1: read data ready.
- AWID_S / AWADDR_S / AWLEN_S / AWSIZE_S / AWBURST_S / AWVALID_S  in; AWREADY_S  out: write address channel.
- WDATA_S / WSTRB_S[3:0] / WLAST_S / WVALID_S  in; WREADY_S  out: write data channel.
- BID_S / BRESP_S[1:0] / BVALID_S  out; BREADY_S  in: write response channel.
- CEB  out  1: SRAM chip enable, active-low.
- WEB  out  1: SRAM write enable, active-low; 1 = read.
- BWEB  out  DATA_WIDTH: SRAM bit write enable, active-low.
- A  out  SRAM_AW: SRAM word address.
- DI  out  DATA_WIDTH: SRAM write data.
- DO  in  DATA_WIDTH: SRAM read data, valid one cycle after a read access.

## Operation
- FSM states: IDLE, READ, WRITE, WRESP. Reset state is IDLE.
- IDLE:
  - ARREADY_S=1 and AWREADY_S=~ARVALID_S, so a read wins over a simultaneous write.
  - AR handshake: latch ID, word address ARADDR_S[15:2], and ARLEN_S; clear the beat counter; issue an SRAM read of the first word this cycle (CEB=0, WEB=1); go to READ.
  - AW handshake: latch ID, word address AWADDR_S[15:2], and AWLEN_S; clear the beat counter; go to WRITE.
- READ:
  - RVALID_S=1, RDATA_S=DO (direct), RID_S=latched ID, RRESP_S=2'b00.
  - RLAST_S=(beat counter==latched LEN).
  - CEB=0 and WEB=1 every cycle.
  - If R handshake, A=current address+1; otherwise A=current address. The re-read keeps DO stable under backpressure.
  - On handshake: increment the address and counter. A handshake on the last beat goes to IDLE.
- WRITE:
  - WREADY_S=1.
  - On W handshake: CEB=0, WEB=0, A=current address, DI=WDATA_S, BWEB byte i = ~{8{WSTRB_S[i]}}; then increment the address and counter.
  - A W handshake with WLAST_S=1 goes to WRESP.
  - Record an error if the beat count at WLAST differs from LEN+1, or if a beat arrives past LEN without WLAST. Excess beats are written anyway.
  - Without a W handshake: CEB=1.
- WRESP: BVALID_S=1, BID_S=latched ID, BRESP_S=2'b10 (SLVERR) if the error was recorded, else 2'b00. B handshake goes to IDLE.
- Burst and size handling: ARSIZE/AWSIZE are assumed word (3'b010). Every burst type is treated as INCR. The word address wraps modulo 2^SRAM_AW. Address bits [1:0] and bits above [15] are ignored.
- Defaults when not driven above: all VALID/READY=0, CEB=1, WEB=1, BWEB all-ones, A=0, DI=0, RDATA_S=0, RID_S=BID_S=0, RLAST_S=0, RRESP_S=BRESP_S=0.

## Timing
- Reset value of every output: state IDLE, so ARREADY_S=1, AWREADY_S=~ARVALID_S, and every other output takes its default above. Latched ID/address/LEN/counter/error registers are cleared.
- Read latency: AR handshake at cycle T gives first RVALID_S at T+1. Under continuous RREADY_S a 16-beat burst completes its last beat at T+16.
- Write: one beat per cycle while WVALID_S is high. The SRAM write occurs in the same cycle as the W handshake. BVALID_S rises the cycle after WLAST.
- The earliest next AR/AW acceptance is the cycle after the final R or B handshake (one-cycle IDLE bubble).
- Holding RREADY_S low keeps RDATA_S, RLAST_S, and RID_S stable.
- VALID signals never depend on the same-cycle READY inputs.
- Reset asserted mid-burst: outputs go to their reset values asynchronously. The transaction is dropped and no R or B response is issued.

## Test plan
- Single read: SRAM word 0x10 preloaded with 0xDEADBEEF; AR addr 0x0000_0040, LEN 0 -> one beat next cycle, RDATA 0xDEADBEEF, RLAST=1, RRESP 0, RID echoes ARID.
- Burst read with backpressure: LEN 3 at addr 0x100, RREADY toggled 1,0,0,1,1,1 -> four beats of words 0x40..0x43 in order, each stable while stalled, RLAST only on the fourth.
- Strobed write then read: AW 0x200 LEN 0, WDATA 0x11223344, WSTRB 4'b0101 over prior 0xFFFFFFFF -> BRESP 0, BID echoes AWID, read-back 0xFF22FF44.
- Simultaneous AR/AW in IDLE: ARREADY=1 and AWREADY=0 that cycle; the write is accepted in the first IDLE cycle after the read burst completes.
- Early WLAST: AWLEN 3 with WLAST on beat 2 -> BRESP 2'b10; beats 1–2 are written.
- Wrap and reset: 2-beat read at word 0x3FFF returns words 0x3FFF then 0x0000; rst asserted mid-burst -> RVALID drops immediately, ARREADY=1, and no stray beats follow.

Source files
------------

// File: rtl/axi_sram_if.sv
// rtl/axi_sram_if.sv - AXI4 slave-port bundle between the bridge and axi_sram_slave.
interface axi_sram_if #(
  parameter int ID_WIDTH   = 8,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  logic [ID_WIDTH-1:0]   ARID_S;
  logic [ADDR_WIDTH-1:0] ARADDR_S;
  logic [3:0]            ARLEN_S;
  logic [2:0]            ARSIZE_S;
  logic [1:0]            ARBURST_S;
  logic                  ARVALID_S;
  logic                  ARREADY_S;

  logic [ID_WIDTH-1:0]   RID_S;
  logic [DATA_WIDTH-1:0] RDATA_S;
  logic [1:0]            RRESP_S;
  logic                  RLAST_S;
  logic                  RVALID_S;
  logic                  RREADY_S;

  logic [ID_WIDTH-1:0]   AWID_S;
  logic [ADDR_WIDTH-1:0] AWADDR_S;
  logic [3:0]            AWLEN_S;
  logic [2:0]            AWSIZE_S;
  logic [1:0]            AWBURST_S;
  logic                  AWVALID_S;
  logic                  AWREADY_S;

  logic [DATA_WIDTH-1:0] WDATA_S;
  logic [STRB_WIDTH-1:0] WSTRB_S;
  logic                  WLAST_S;
  logic                  WVALID_S;
  logic                  WREADY_S;

  logic [ID_WIDTH-1:0]   BID_S;
  logic [1:0]            BRESP_S;
  logic                  BVALID_S;
  logic                  BREADY_S;

  modport slave (
    input  ARID_S, ARADDR_S, ARLEN_S, ARSIZE_S, ARBURST_S, ARVALID_S,
    output ARREADY_S,
    output RID_S, RDATA_S, RRESP_S, RLAST_S, RVALID_S,
    input  RREADY_S,
    input  AWID_S, AWADDR_S, AWLEN_S, AWSIZE_S, AWBURST_S, AWVALID_S,
    output AWREADY_S,
    input  WDATA_S, WSTRB_S, WLAST_S, WVALID_S,
    output WREADY_S,
    output BID_S, BRESP_S, BVALID_S,
    input  BREADY_S
  );

  modport master (
    output ARID_S, ARADDR_S, ARLEN_S, ARSIZE_S, ARBURST_S, ARVALID_S,
    input  ARREADY_S,
    input  RID_S, RDATA_S, RRESP_S, RLAST_S, RVALID_S,
    output RREADY_S,
    output AWID_S, AWADDR_S, AWLEN_S, AWSIZE_S, AWBURST_S, AWVALID_S,
    input  AWREADY_S,
    output WDATA_S, WSTRB_S, WLAST_S, WVALID_S,
    input  WREADY_S,
    input  BID_S, BRESP_S, BVALID_S,
    output BREADY_S
  );
endinterface

// File: rtl/axi_sram_slave.sv
// rtl/axi_sram_slave.sv - AXI4 INCR-burst slave driving a single-port synchronous SRAM.
module axi_sram_slave #(
  parameter int ID_WIDTH   = 8,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int SRAM_AW    = 14
) (
  input  logic                  clk,
  input  logic                  rst,
  axi_sram_if.slave             s,
  output logic                  CEB,
  output logic                  WEB,
  output logic [DATA_WIDTH-1:0] BWEB,
  output logic [SRAM_AW-1:0]    A,
  output logic [DATA_WIDTH-1:0] DI,
  input  logic [DATA_WIDTH-1:0] DO
);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  typedef enum logic [1:0] {IDLE, READ, WRITE, WRESP} state_t;

  state_t              state;
  logic [ID_WIDTH-1:0] id_q;
  logic [SRAM_AW-1:0]  addr_q;
  logic [3:0]          len_q;
  logic [4:0]          cnt_q;
  logic                err_q;

  logic [SRAM_AW-1:0]  ar_word;
  logic [SRAM_AW-1:0]  aw_word;
  logic                last_beat;
  logic                unused_ok;

  assign ar_word   = s.ARADDR_S[SRAM_AW+1:2];
  assign aw_word   = s.AWADDR_S[SRAM_AW+1:2];
  assign last_beat = (cnt_q == {1'b0, len_q});
  assign unused_ok = ^{s.ARSIZE_S, s.ARBURST_S, s.AWSIZE_S, s.AWBURST_S,
                       s.ARADDR_S[ADDR_WIDTH-1:SRAM_AW+2], s.ARADDR_S[1:0],
                       s.AWADDR_S[ADDR_WIDTH-1:SRAM_AW+2], s.AWADDR_S[1:0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      id_q   <= '0;
      addr_q <= '0;
      len_q  <= '0;
      cnt_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (s.ARVALID_S) begin
            id_q   <= s.ARID_S;
            addr_q <= ar_word;
            len_q  <= s.ARLEN_S;
            cnt_q  <= '0;
            state  <= READ;
          end else if (s.AWVALID_S) begin
            id_q   <= s.AWID_S;
            addr_q <= aw_word;
            len_q  <= s.AWLEN_S;
            cnt_q  <= '0;
            err_q  <= 1'b0;
            state  <= WRITE;
          end
        end
        READ: begin
          if (s.RREADY_S) begin
            addr_q <= addr_q + 1'b1;
            cnt_q  <= cnt_q + 5'd1;
            if (last_beat) state <= IDLE;
          end
        end
        WRITE: begin
          if (s.WVALID_S) begin
            addr_q <= addr_q + 1'b1;
            cnt_q  <= cnt_q + 5'd1;
            // Sticky: a short burst ends early, a long one overruns LEN; both still write.
            if (s.WLAST_S ? !last_beat : (cnt_q > {1'b0, len_q})) err_q <= 1'b1;
            if (s.WLAST_S) state <= WRESP;
          end
        end
        WRESP: begin
          if (s.BREADY_S) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    s.ARREADY_S = 1'b0;
    s.AWREADY_S = 1'b0;
    s.RVALID_S  = 1'b0;
    s.RDATA_S   = '0;
    s.RID_S     = '0;
    s.RRESP_S   = 2'b00;
    s.RLAST_S   = 1'b0;
    s.WREADY_S  = 1'b0;
    s.BVALID_S  = 1'b0;
    s.BID_S     = '0;
    s.BRESP_S   = 2'b00;
    CEB         = 1'b1;
    WEB         = 1'b1;
    BWEB        = '1;
    A           = '0;
    DI          = '0;
    case (state)
      IDLE: begin
        s.ARREADY_S = 1'b1;
        s.AWREADY_S = ~s.ARVALID_S;
        if (s.ARVALID_S) begin
          CEB = 1'b0;
          A   = ar_word;
        end
      end
      READ: begin
        s.RVALID_S = 1'b1;
        s.RDATA_S  = DO;
        s.RID_S    = id_q;
        s.RLAST_S  = last_beat;
        CEB        = 1'b0;
        // Prefetch the next word on acceptance; otherwise re-read to hold DO steady.
        A          = s.RREADY_S ? addr_q + 1'b1 : addr_q;
      end
      WRITE: begin
        s.WREADY_S = 1'b1;
        if (s.WVALID_S) begin
          CEB = 1'b0;
          WEB = 1'b0;
          A   = addr_q;
          DI  = s.WDATA_S;
          for (int b = 0; b < STRB_WIDTH; b++) BWEB[8*b +: 8] = {8{~s.WSTRB_S[b]}};
        end
      end
      WRESP: begin
        s.BVALID_S = 1'b1;
        s.BID_S    = id_q;
        s.BRESP_S  = err_q ? 2'b10 : 2'b00;
      end
      default: ;
    endcase
  end
endmodule
